// File: rtl/data_bus_responder_if.sv
//------------------------------------------------------------------------------
// Module      : data_bus_responder_if
// Description : Memory-stage load/store bus plus command FIFO output handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_bus_responder_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic        bus_wr_en;
  logic [31:0] bus_rd_data;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;

  modport master (
    output bus_addr, bus_wr_data, bus_wr_en, cmd_ready,
    input  bus_rd_data, cmd_valid, cmd_data
  );

  modport slave (
    input  bus_addr, bus_wr_data, bus_wr_en, cmd_ready,
    output bus_rd_data, cmd_valid, cmd_data
  );
endinterface

`default_nettype wire

// File: rtl/data_bus_responder.sv
//------------------------------------------------------------------------------
// Module      : data_bus_responder
// Description : Word RAM with zero-latency reads, command FIFO, STATUS register
//               and optional free-running CYCLE counter (BUS_CYCLE_COUNTER_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_bus_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  data_bus_responder_if.slave   bus
);

  localparam int c_RAM_AW  = $clog2(RAM_WORDS);
  localparam int c_FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_FIFO_AW + 1;

  localparam logic [31:0] c_ADDR_CMD    = 32'h8000_0000;
  localparam logic [31:0] c_ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] c_ADDR_CYCLE  = 32'h8000_0008;

  // Address decode: the byte offset is irrelevant, every access is a full word.
  logic [31:0]         w_word_addr;
  logic                w_ram_hit;
  logic                w_cmd_hit;
  logic                w_status_hit;
  logic                w_cycle_hit;
  logic [c_RAM_AW-1:0] w_ram_idx;
  logic                w_wr_en;
  logic                w_unused_addr;

  assign w_word_addr   = {bus.bus_addr[31:2], 2'b00};
  assign w_ram_hit     = (bus.bus_addr[31:c_RAM_AW+2] == '0);
  assign w_ram_idx     = bus.bus_addr[c_RAM_AW+1:2];
  assign w_cmd_hit     = (w_word_addr == c_ADDR_CMD);
  assign w_status_hit  = (w_word_addr == c_ADDR_STATUS);
  assign w_cycle_hit   = (w_word_addr == c_ADDR_CYCLE);
  assign w_wr_en       = bus.bus_wr_en && !reset;
  assign w_unused_addr = &{1'b0, bus.bus_addr[1:0]};

  // Data RAM: not reset, written only outside reset.
  logic [31:0] r_ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (w_wr_en && w_ram_hit) begin
      r_ram[w_ram_idx] <= bus.bus_wr_data;
    end
  end

  // Command FIFO
  logic [31:0]          r_fifo [FIFO_DEPTH];
  logic [c_FIFO_AW-1:0] r_wr_ptr;
  logic [c_FIFO_AW-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;

  logic w_empty;
  logic w_full;
  logic w_cmd_valid;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_ovf_set;
  logic w_status_wr;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_cmd_valid = !w_empty && !reset;
  assign w_pop       = w_cmd_valid && bus.cmd_ready;
  assign w_push_req  = w_wr_en && w_cmd_hit;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = w_push_req && w_full && !w_pop;
  assign w_status_wr = w_wr_en && w_status_hit;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.bus_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_FIFO_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      r_overflow <= w_ovf_set || (r_overflow && !w_status_wr);
    end
  end

  // Cycle counter
  logic [31:0] w_cycle_rd;

`ifdef BUS_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
    end else if (w_wr_en && w_cycle_hit) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_cycle_rd = r_cycle;
`else
  assign w_cycle_rd = '0;
`endif

  // Read mux
  logic [31:0] w_status;
  logic [31:0] w_rd_data;

  assign w_status = {16'h0000, 8'(r_count), 5'b00000, r_overflow, w_full, w_empty};

  always_comb begin
    w_rd_data = '0;
    if (w_ram_hit) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_status_hit) begin
      w_rd_data = w_status;
    end else if (w_cycle_hit) begin
      w_rd_data = w_cycle_rd;
    end
  end

  assign bus.bus_rd_data = w_rd_data;
  assign bus.cmd_valid   = w_cmd_valid;
  assign bus.cmd_data    = r_fifo[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_data_bus_responder
// Description : Table vectors, directed corner sequences and random traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_bus_responder;
  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_CMD    = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_bus_responder_if bus_if();

  data_bus_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_known [RAM_WORDS];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a, output bit known);
    logic [31:0] word;
    int          idx;
    word  = {a[31:2], 2'b00};
    known = 1'b1;
    if ((a >> 2) < RAM_WORDS) begin
      idx   = int'(a >> 2);
      known = m_known[idx];
      return m_ram[idx];
    end
    if (word == A_STATUS)
      return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == FIFO_DEPTH, m_q.size() == 0};
`ifdef BUS_CYCLE_COUNTER_EN
    if (word == A_CYCLE) return m_cyc;
`endif
    return 32'h0;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic rdy, input logic rst);
    logic [31:0] word;
    bit          pop, full, set;
    word = {a[31:2], 2'b00};
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'h0;
      return;
    end
    pop  = (m_q.size() != 0) && rdy;
    full = (m_q.size() == FIFO_DEPTH);
    set  = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (we && word == A_CMD) begin
      if (!full || pop) m_q.push_back(wd);
      else set = 1'b1;
    end
    m_ovf = set || (m_ovf && !(we && word == A_STATUS));
    if (we && (a >> 2) < RAM_WORDS) begin
      m_ram[int'(a >> 2)]   = wd;
      m_known[int'(a >> 2)] = 1'b1;
    end
    m_cyc = (we && word == A_CYCLE) ? 32'h0 : m_cyc + 32'd1;
  endtask

  // One bus cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input logic rdy, input logic rst);
    logic [31:0] exp;
    bit          known;
    bit          ev;
    @(negedge clk);
    bus_if.bus_addr    = a;
    bus_if.bus_wr_data = wd;
    bus_if.bus_wr_en   = we;
    bus_if.cmd_ready   = rdy;
    reset              = rst;
    #1;
    exp = model_rd(a, known);
    if (known) chk("model_rd_data", bus_if.bus_rd_data, exp);
    ev = (m_q.size() != 0) && !rst;
    chk("model_cmd_valid", {31'b0, bus_if.cmd_valid}, {31'b0, ev});
    if (ev) chk("model_cmd_data", bus_if.cmd_data, m_q[0]);
    model_edge(a, wd, we, rdy, rst);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] st;
    logic [31:0] first_d;
    logic [31:0] last_d;

    reset              = 1'b1;
    bus_if.bus_addr    = '0;
    bus_if.bus_wr_data = '0;
    bus_if.bus_wr_en   = 1'b0;
    bus_if.cmd_ready   = 1'b0;
    m_ovf              = 1'b0;
    m_cyc              = 32'h0;

    // Reset state
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_status", bus_if.bus_rd_data, 32'h0000_0001);
    chk("reset_valid", {31'b0, bus_if.cmd_valid}, 32'h0);

    // Vector table
    tbl.push_back('{32'h10, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{A_CMD, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{32'h4000_0000, 32'hCAFE, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0});
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{A_CMD, 32'(k), 1'b1, 1'b0, 1'b1, 32'h0, (k > 1), (k > 1) ? 32'h1 : 32'h0});
    tbl.push_back('{A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0802, 1'b1, 32'h1});
    tbl.push_back('{A_CMD, 32'h9, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h1});
    tbl.push_back('{A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0806, 1'b1, 32'h1});
    for (int k = 1; k <= 8; k++) begin
      st = (32'(9 - k) << 8) | 32'h4 | ((k == 1) ? 32'h2 : 32'h0);
      tbl.push_back('{A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, st, 1'b1, 32'(k)});
    end
    tbl.push_back('{A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0, 32'h0});
    tbl.push_back('{A_STATUS, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 32'h0});
    tbl.push_back('{A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].rdy, 1'b0);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), bus_if.bus_rd_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_valid", i), {31'b0, bus_if.cmd_valid}, {31'b0, tbl[i].exp_v});
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), bus_if.cmd_data, tbl[i].exp_d);
    end

    // Push into a full FIFO while it pops
    for (int k = 1; k <= 8; k++) step(A_CMD, 32'hB0 + 32'(k), 1'b1, 1'b0, 1'b0);
    step(A_CMD, 32'hA5, 1'b1, 1'b1, 1'b0);
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("push_pop_full_status", bus_if.bus_rd_data, 32'h0000_0802);
    first_d = 32'h0;
    last_d  = 32'h0;
    for (int k = 0; k < 8; k++) begin
      step(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0);
      if (k == 0) first_d = bus_if.cmd_data;
      last_d = bus_if.cmd_data;
    end
    chk("push_pop_first", first_d, 32'hB2);
    chk("push_pop_last", last_d, 32'hA5);
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("push_pop_drained", bus_if.bus_rd_data, 32'h0000_0001);

    // Reset mid-stream, RAM preserved
    for (int k = 1; k <= 3; k++) step(A_CMD, 32'(k), 1'b1, 1'b0, 1'b0);
    step(32'h10, 32'h1234, 1'b1, 1'b0, 1'b0);
    step(32'h10, 32'hFFFF, 1'b1, 1'b1, 1'b1);
    step(A_CMD, 32'hEEEE, 1'b1, 1'b1, 1'b1);
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("midreset_status", bus_if.bus_rd_data, 32'h0000_0001);
    chk("midreset_valid", {31'b0, bus_if.cmd_valid}, 32'h0);
    step(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("midreset_ram", bus_if.bus_rd_data, 32'h0000_1234);

    // Cycle counter
`ifdef BUS_CYCLE_COUNTER_EN
    step(A_CYCLE, 32'hABCD, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cycle_after_5", bus_if.bus_rd_data, 32'd5);
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle;
    m_cyc = 32'hFFFF_FFFF;
    step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cycle_max", bus_if.bus_rd_data, 32'hFFFF_FFFF);
    step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cycle_wrap", bus_if.bus_rd_data, 32'h0);
`else
    step(A_CYCLE, 32'h55, 1'b1, 1'b0, 1'b0);
    step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cycle_disabled", bus_if.bus_rd_data, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        1, 5:    a = A_CMD | $urandom_range(0, 3);
        2:       a = A_STATUS | $urandom_range(0, 3);
        3:       a = A_CYCLE | $urandom_range(0, 3);
        default: a = ($urandom_range(0, 1) != 0) ? (32'h0000_1000 + ($urandom_range(0, 255) << 2))
                                                 : 32'h8000_000C;
      endcase
      step(a, $urandom, $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Clocking SHALL be a single clock `clk`; reset `reset` SHALL be synchronous and active-high.
REQ-002 Parameter RAM_WORDS, default 1024, SHALL set the data RAM depth in 32-bit words (power of two, 16..65536).
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the command FIFO depth in words (power of two, 2..128).
REQ-004 Port clk, input, 1 bit: clock, rising edge.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset.
REQ-006 Port bus_addr, input, 32 bits: byte address from the pipeline memory stage.
REQ-007 Port bus_wr_data, input, 32 bits: store data.
REQ-008 Port bus_wr_en, input, 1 bit: store strobe, sampled at the rising edge.
REQ-009 Port bus_rd_data, output, 32 bits: load data, combinational from bus_addr.
REQ-010 Port cmd_valid, output, 1 bit: command FIFO head is valid.
REQ-011 Port cmd_data, output, 32 bits: command FIFO head word.
REQ-012 Port cmd_ready, input, 1 bit: consumer accepts the head word.

Function
REQ-013 Address map SHALL be: RAM at 0x0000_0000..RAM_WORDS*4-1; CMD at 0x8000_0000; STATUS at 0x8000_0004; CYCLE at 0x8000_0008; all other addresses unmapped.
REQ-014 The block SHALL ignore bus_addr[1:0]; accesses are whole words only.
REQ-015 RAM reads SHALL be zero-latency: bus_rd_data = ram[bus_addr[2 +: log2(RAM_WORDS)]] in the same cycle.
REQ-016 A RAM write SHALL update the word at the rising edge where bus_wr_en=1; a read of the same address in that cycle SHALL return the old value, and a read in the next cycle SHALL return the new value.
REQ-017 Unmapped reads and CMD reads SHALL return 0x0000_0000; unmapped writes SHALL have no effect.
REQ-018 A write to CMD SHALL push bus_wr_data into the FIFO when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-019 A write to CMD when the FIFO is full with no pop SHALL drop the data and set the sticky flag overflow=1.
REQ-020 A pop SHALL occur at the rising edge where cmd_valid=1 and cmd_ready=1; cmd_valid SHALL equal !empty.
REQ-021 cmd_data SHALL hold the oldest entry and remain stable while cmd_valid=1 and cmd_ready=0.
REQ-022 A push into an empty FIFO SHALL assert cmd_valid in the next cycle; there is no bypass path.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 STATUS reads SHALL return: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count (0..FIFO_DEPTH), all other bits 0.
REQ-025 Any write to STATUS SHALL clear overflow; if an overflow occurs in the same cycle, overflow SHALL remain 1 (set wins).
REQ-026 The cycle counter (see Configuration) SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-027 A write to CYCLE SHALL load the counter with 0 regardless of bus_wr_data; the clear SHALL take precedence over the increment.

Reset
REQ-028 Reset SHALL clear the FIFO (count=0, pointers=0), overflow=0, and the counter=0, and SHALL force cmd_valid=0.
REQ-029 RAM contents SHALL NOT be affected by reset; a bus_wr_en asserted during reset SHALL be ignored for all targets, RAM included.
REQ-030 Reset asserted mid-stream SHALL discard all queued commands, and no pop SHALL occur in the reset cycle.
REQ-031 Out of reset, bus_rd_data SHALL still follow REQ-015..REQ-017; it is not a registered output.

Configuration
REQ-032 Macro BUS_CYCLE_COUNTER_EN defined: the CYCLE register SHALL exist per REQ-026/REQ-027.
REQ-033 Macro BUS_CYCLE_COUNTER_EN undefined: no counter flops SHALL exist, CYCLE reads SHALL return 0, and CYCLE writes SHALL be ignored.

Verification
REQ-034 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF; the same-cycle read during the write returns the old value.
REQ-035 With cmd_ready=0, write 1..8 to CMD -> STATUS=0x0000_0802; a 9th write of 9 -> STATUS=0x0000_0806 and 9 is not queued.
REQ-036 From the full FIFO, hold cmd_ready=1 -> cmd_data sequence 1..8 on consecutive cycles, then cmd_valid=0 and STATUS=0x0000_0005; write STATUS -> STATUS=0x0000_0001.
REQ-037 With the FIFO full, write CMD=0xA5 in the same cycle as a pop -> count stays 8, overflow stays 0, and 0xA5 emerges last.
REQ-038 With BUS_CYCLE_COUNTER_EN defined, write CYCLE, wait 5 cycles, read -> 5; force the counter to 0xFFFF_FFFF, one cycle later -> 0. With the macro undefined -> reads return 0.
REQ-039 Assert reset with 3 entries queued and RAM[4]=0x1234 -> cmd_valid=0 and STATUS=0x0000_0001 after reset, while RAM[4] still reads 0x1234.
